// File: rtl/kd_tree_pkg.sv
// kd_tree_pkg: shared FSM encoding, index limit and node word field positions
package kd_tree_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DRAIN, ST_DONE} state_t;

    localparam int IDX_MAX = 4;
    localparam int MED_MSB = 21;
    localparam int MED_LSB = 11;
    localparam int IDX_MSB = 2;
    localparam int IDX_LSB = 0;

endpackage

// File: rtl/kd_cfg_rb_check.sv
// kd_cfg_rb_check: delays each node write by one cycle and compares the node readback on median and index fields
module kd_cfg_rb_check
    import kd_tree_pkg::*;
#(
    parameter int NUM_NODES     = 31,
    parameter int STORAGE_WIDTH = 22
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               clr,
    input  logic [NUM_NODES-1:0]               node_wen,
    input  logic [STORAGE_WIDTH-1:0]           node_wdata,
    input  logic [NUM_NODES*STORAGE_WIDTH-1:0] node_rdata,
    output logic                               err_rb
);

    logic [NUM_NODES-1:0]       wen_d;
    logic [MED_MSB-MED_LSB:0]   med_d;
    logic [IDX_MSB-IDX_LSB:0]   idx_d;
    logic [STORAGE_WIDTH-1:0]   slice;
    logic                       mismatch;
    logic                       unused_rb;

    // The don't-care middle bits of both words never take part in the check.
    assign unused_rb = ^{node_rdata, node_wdata};

    // Remember which node was written and the fields it should now hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wen_d <= '0;
            med_d <= '0;
            idx_d <= '0;
        end else begin
            wen_d <= node_wen;
            med_d <= node_wdata[MED_MSB:MED_LSB];
            idx_d <= node_wdata[IDX_MSB:IDX_LSB];
        end
    end

    // Compare the readback of the node written one cycle earlier.
    always_comb begin
        mismatch = 1'b0;
        slice    = '0;
        for (int k = 0; k < NUM_NODES; k++) begin
            slice = node_rdata[k*STORAGE_WIDTH +: STORAGE_WIDTH];
            if (wen_d[k] && (slice[MED_MSB:MED_LSB] != med_d || slice[IDX_MSB:IDX_LSB] != idx_d))
                mismatch = 1'b1;
        end
    end

    // Sticky mismatch flag, cleared when a new load begins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_rb <= 1'b0;
        else        err_rb <= clr ? 1'b0 : (err_rb | mismatch);
    end

endmodule

// File: rtl/kd_node_cfg_ctrl.sv
// kd_node_cfg_ctrl: loads NUM_NODES kd-tree node words in order; readback checking enabled by KD_NODE_CFG_READBACK_EN
module kd_node_cfg_ctrl
    import kd_tree_pkg::*;
#(
    parameter int NUM_NODES     = 31,
    parameter int STORAGE_WIDTH = 22,
    parameter int ADDR_W        = 5
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic                               cfg_valid,
    output logic                               cfg_ready,
    input  logic [STORAGE_WIDTH-1:0]           cfg_data,
    output logic [NUM_NODES-1:0]               node_wen,
    output logic [STORAGE_WIDTH-1:0]           node_wdata,
    input  logic [NUM_NODES*STORAGE_WIDTH-1:0] node_rdata,
    output logic                               busy,
    output logic                               done,
    output logic                               err_idx,
    output logic                               err_rb
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_NODES - 1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] cnt;
    logic              drain;
    logic              accept;
    logic              restart;

    assign accept  = cfg_valid & cfg_ready;
    assign restart = start & (state == ST_IDLE || state == ST_DONE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next state: DRAIN holds two cycles so the last write and its readback settle.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  state_nxt = start ? ST_LOAD : ST_IDLE;
            ST_LOAD:  state_nxt = (accept && cnt == LAST) ? ST_DRAIN : ST_LOAD;
            ST_DRAIN: state_nxt = drain ? ST_DONE : ST_DRAIN;
            ST_DONE:  state_nxt = start ? ST_LOAD : ST_DONE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // State-decoded handshake and status outputs.
    always_comb begin
        cfg_ready = (state == ST_LOAD);
        busy      = (state == ST_LOAD) || (state == ST_DRAIN);
        done      = (state == ST_DONE);
    end

    // Node counter holds at the last node, drain cycle toggle, sticky index error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            drain   <= 1'b0;
            err_idx <= 1'b0;
        end else begin
            cnt     <= restart ? '0 : (accept && cnt != LAST) ? cnt + 1'b1 : cnt;
            drain   <= (state == ST_DRAIN) ? ~drain : 1'b0;
            err_idx <= restart ? 1'b0 : (accept && cfg_data[IDX_MSB:IDX_LSB] > 3'(IDX_MAX)) ? 1'b1 : err_idx;
        end
    end

    // One-cycle write strobe to the addressed node with the accepted word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            node_wen   <= '0;
            node_wdata <= '0;
        end else begin
            node_wen   <= accept ? (NUM_NODES'(1) << cnt) : '0;
            node_wdata <= accept ? cfg_data : node_wdata;
        end
    end

`ifdef KD_NODE_CFG_READBACK_EN
    kd_cfg_rb_check #(
        .NUM_NODES     (NUM_NODES),
        .STORAGE_WIDTH (STORAGE_WIDTH)
    ) u_rb_check (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (restart),
        .node_wen   (node_wen),
        .node_wdata (node_wdata),
        .node_rdata (node_rdata),
        .err_rb     (err_rb)
    );
`else
    logic unused_rdata;
    assign unused_rdata = ^node_rdata;
    assign err_rb       = 1'b0;
`endif

endmodule

// File: tb/tb_kd_node_cfg_ctrl.sv
// tb_kd_node_cfg_ctrl: directed checks of node load order, drain timing, error flags and reset
module tb_kd_node_cfg_ctrl;

    localparam int NN = 31;
    localparam int SW = 22;
    localparam int AW = 5;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           start = 1'b0;
    logic           cfg_valid = 1'b0;
    logic [SW-1:0]  cfg_data = '0;
    logic           cfg_ready;
    logic [NN-1:0]  node_wen;
    logic [SW-1:0]  node_wdata;
    logic [NN*SW-1:0] node_rdata;
    logic           busy, done, err_idx, err_rb;

    int total = 0;
    int bad = 0;
    int pulses = 0;
    bit corrupt = 1'b0;
    logic [SW-1:0] mem [NN];

    kd_node_cfg_ctrl #(.NUM_NODES(NN), .STORAGE_WIDTH(SW), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready), .cfg_data(cfg_data), .node_wen(node_wen),
        .node_wdata(node_wdata), .node_rdata(node_rdata), .busy(busy),
        .done(done), .err_idx(err_idx), .err_rb(err_rb)
    );

    always #5 clk = ~clk;

    // Node storage model; optionally corrupts node 12's median by +1.
    always @(posedge clk)
        for (int k = 0; k < NN; k++)
            if (node_wen[k]) mem[k] <= (corrupt && k == 12) ? node_wdata + SW'(1 << 11) : node_wdata;

    always_comb
        for (int k = 0; k < NN; k++) node_rdata[k*SW +: SW] = mem[k];

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Every write strobe must be one-hot.
    always @(negedge clk)
        if (node_wen != '0) begin
            pulses++;
            chk("wen_onehot", 64'($countones(node_wen)), 64'd1);
        end

    function automatic logic [SW-1:0] word(int k, int idx);
        logic [10:0] m;
        m = 11'(k * 37 - 500);
        return {m, 8'hA5, 3'(idx)};
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start;
        start = 1'b1;
        step;
        start = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int p0, n, cyc, v;
        // Reset state
        #1 rst_n = 1'b0;
        #1;
        chk("rst_wen", 64'(node_wen), 64'd0);
        chk("rst_wdata", 64'(node_wdata), 64'd0);
        chk("rst_ready", 64'(cfg_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err_idx", 64'(err_idx), 64'd0);
        chk("rst_err_rb", 64'(err_rb), 64'd0);
        step; step;
        rst_n = 1'b1;
        step;
        chk("idle_ready", 64'(cfg_ready), 64'd0);

        // Back-to-back load
        p0 = pulses;
        do_start;
        chk("load_ready", 64'(cfg_ready), 64'd1);
        chk("load_busy", 64'(busy), 64'd1);
        for (int k = 0; k < NN; k++) begin
            cfg_valid = 1'b1;
            cfg_data  = word(k, k % 5);
            step;
            chk("b2b_wen", 64'(node_wen), 64'd1 << k);
            chk("b2b_wdata", 64'(node_wdata), 64'(word(k, k % 5)));
        end
        cfg_valid = 1'b0;
        chk("drain1_done", 64'(done), 64'd0);
        chk("drain1_ready", 64'(cfg_ready), 64'd0);
        chk("drain1_busy", 64'(busy), 64'd1);
        step;
        chk("drain2_done", 64'(done), 64'd0);
        chk("drain2_wen", 64'(node_wen), 64'd0);
        step;
        chk("done_level", 64'(done), 64'd1);
        chk("done_busy", 64'(busy), 64'd0);
        chk("b2b_err_idx", 64'(err_idx), 64'd0);
        chk("b2b_err_rb", 64'(err_rb), 64'd0);
        chk("b2b_pulses", 64'(pulses - p0), 64'(NN));
        chk("b2b_mem30", 64'(mem[30]), 64'(word(30, 0)));
        step;
        chk("done_hold", 64'(done), 64'd1);

        // Random valid with an ignored start mid-load
        p0 = pulses;
        do_start;
        chk("restart_done", 64'(done), 64'd0);
        n = 0;
        cyc = 0;
        while (n < NN && cyc < 600) begin
            v = int'($urandom_range(0, 1));
            cfg_valid = v[0];
            cfg_data  = word(n + 40, n % 5);
            start     = (cyc == 20);
            step;
            cyc++;
            if (v[0]) begin
                chk("rnd_wen", 64'(node_wen), 64'd1 << n);
                chk("rnd_wdata", 64'(node_wdata), 64'(word(n + 40, n % 5)));
                n++;
            end else begin
                chk("rnd_idle_wen", 64'(node_wen), 64'd0);
            end
            if (cyc == 21) chk("start_ignored_busy", 64'(busy), 64'(n < NN));
        end
        start = 1'b0;
        cfg_valid = 1'b0;
        chk("rnd_count", 64'(n), 64'(NN));
        step; step;
        chk("rnd_done", 64'(done), 64'd1);
        chk("rnd_pulses", 64'(pulses - p0), 64'(NN));
        for (int k = 0; k < NN; k++)
            chk("rnd_mem", 64'(mem[k]), 64'(word(k + 40, k % 5)));

        // Out-of-range index on node 7
        do_start;
        for (int k = 0; k < NN; k++) begin
            cfg_valid = 1'b1;
            cfg_data  = word(k, (k == 7) ? 6 : k % 5);
            step;
            if (k == 6) chk("pre_err_idx", 64'(err_idx), 64'd0);
            if (k == 7) begin
                chk("err_idx_set", 64'(err_idx), 64'd1);
                chk("bad_idx_wen", 64'(node_wen), 64'd1 << 7);
            end
        end
        cfg_valid = 1'b0;
        step; step;
        chk("err_idx_done", 64'(done), 64'd1);
        chk("err_idx_sticky", 64'(err_idx), 64'd1);
        chk("bad_idx_mem7", 64'(mem[7]), 64'(word(7, 6)));
        do_start;
        chk("err_idx_clear", 64'(err_idx), 64'd0);
        chk("err_idx_clr_done", 64'(done), 64'd0);

        // Reset after 10 words
        for (int k = 0; k < 10; k++) begin
            cfg_valid = 1'b1;
            cfg_data  = word(k, k % 5);
            step;
        end
        chk("pre_rst_wen", 64'(node_wen), 64'd1 << 9);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_wen", 64'(node_wen), 64'd0);
        chk("mid_rst_wdata", 64'(node_wdata), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_ready", 64'(cfg_ready), 64'd0);
        p0 = pulses;
        step; step;
        rst_n = 1'b1;
        step; step;
        chk("post_rst_pulses", 64'(pulses - p0), 64'd0);
        chk("post_rst_busy", 64'(busy), 64'd0);
        cfg_valid = 1'b0;
        do_start;
        for (int k = 0; k < NN; k++) begin
            cfg_valid = 1'b1;
            cfg_data  = word(k + 3, k % 5);
            step;
            if (k == 0) chk("reload_node0", 64'(node_wen), 64'd1);
        end
        cfg_valid = 1'b0;
        step; step;
        chk("reload_done", 64'(done), 64'd1);

`ifdef KD_NODE_CFG_READBACK_EN
        // Corrupted readback on node 12
        corrupt = 1'b1;
        do_start;
        for (int k = 0; k < NN; k++) begin
            cfg_valid = 1'b1;
            cfg_data  = word(k, k % 5);
            step;
            chk("rb_err", 64'(err_rb), 64'(k >= 14));
        end
        cfg_valid = 1'b0;
        step; step;
        chk("rb_done", 64'(done), 64'd1);
        chk("rb_sticky", 64'(err_rb), 64'd1);
        corrupt = 1'b0;
        do_start;
        chk("rb_clear", 64'(err_rb), 64'd0);
`else
        chk("no_rb_err", 64'(err_rb), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
